// File: rtl/arith_result_fifo.sv
// First-word-fall-through result buffer behind arithmetic_unit, with running
// overflow count, sticky overflow flag and wrapping signed sum of accepted entries.
module arith_result_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8,
   parameter int ACC_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_q,
   input  logic                   in_ov,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_q,
   output logic                   out_ov,
   output logic [$clog2(DEPTH):0] count,
   output logic [CNT_W-1:0]       ov_count,
   output logic                   ov_sticky,
   output logic [ACC_W-1:0]       sum,
   input  logic                   clr_stats
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0]        r_mem_q  [DEPTH];
   logic                    r_mem_ov [DEPTH];
   logic [AW-1:0]           r_wptr;
   logic [AW-1:0]           r_rptr;
   logic [CW-1:0]           r_count;
   logic [CNT_W-1:0]        r_ov_count;
   logic                    r_ov_sticky;
   logic [ACC_W-1:0]        r_sum;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic signed [ACC_W-1:0] w_q_ext;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   // A full FIFO refuses a push even if a pop happens in the same cycle.
   assign w_push  = in_valid && !w_full;
   assign w_pop   = out_ready && !w_empty;
   assign w_q_ext = ACC_W'($signed(in_q));

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_q[r_wptr]  <= in_q;
         r_mem_ov[r_wptr] <= in_ov;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Clear wins over a same-cycle push; the entry is still stored above.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ov_count  <= '0;
         r_ov_sticky <= 1'b0;
         r_sum       <= '0;
      end else if (clr_stats) begin
         r_ov_count  <= '0;
         r_ov_sticky <= 1'b0;
         r_sum       <= '0;
      end else if (w_push) begin
         r_sum <= r_sum + w_q_ext;
         if (in_ov) begin
            r_ov_sticky <= 1'b1;
            if (r_ov_count != '1) begin
               r_ov_count <= r_ov_count + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      in_ready  = !w_full;
      out_valid = !w_empty;
      out_q     = '0;
      out_ov    = 1'b0;
      if (!w_empty) begin
         out_q  = r_mem_q[r_rptr];
         out_ov = r_mem_ov[r_rptr];
      end
   end

   assign count     = r_count;
   assign ov_count  = r_ov_count;
   assign ov_sticky = r_ov_sticky;
   assign sum       = r_sum;

endmodule

// File: tb/tb_arith_result_fifo.sv
// Self-checking bench for arith_result_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_arith_result_fifo;
   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0] q;
      logic       ov;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_q;
   logic       in_ov;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_q;
   logic       out_ov;
   logic [2:0] count;
   logic [7:0] ov_count;
   logic       ov_sticky;
   logic [7:0] sum;
   logic       clr_stats;

   int n_checks = 0;
   int n_pass   = 0;

   ent_t m_q[$];
   int   m_ovc;
   bit   m_sticky;
   int   m_sum;

   arith_result_fifo #(
      .WIDTH(4),
      .DEPTH(DEPTH),
      .CNT_W(8),
      .ACC_W(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_q     (in_q),
      .in_ov    (in_ov),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_q    (out_q),
      .out_ov   (out_ov),
      .count    (count),
      .ov_count (ov_count),
      .ov_sticky(ov_sticky),
      .sum      (sum),
      .clr_stats(clr_stats)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic m_reset();
      m_q.delete();
      m_ovc    = 0;
      m_sticky = 0;
      m_sum    = 0;
   endtask

   // Advance one clock edge and apply the same transfer to the reference model.
   task automatic cycle();
      bit   push;
      bit   pop;
      ent_t e;
      push = in_valid && (m_q.size() < DEPTH);
      pop  = out_ready && (m_q.size() > 0);
      e.q  = in_q;
      e.ov = in_ov;
      @(posedge clk);
      #1;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(e);
      if (clr_stats) begin
         m_ovc    = 0;
         m_sticky = 0;
         m_sum    = 0;
      end else if (push) begin
         m_sum = m_sum + int'($signed(e.q));
         if (e.ov) begin
            m_sticky = 1;
            if (m_ovc < 255) m_ovc++;
         end
      end
   endtask

   task automatic push1(input logic [3:0] q, input logic ov);
      in_valid = 1'b1;
      in_q     = q;
      in_ov    = ov;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 0; in_q = 0; in_ov = 0; out_ready = 0; clr_stats = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_reset();
      push1(4'h3, 1'b1);
      push1(4'h5, 1'b0);
      n_checks++; if (count !== 3'd2) $display("FAIL pre_reset_count: got %0d want 2", count); else n_pass++;
      #2 rst = 1'b1;
      #1;
      m_reset();
      n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_q !== 4'h0 || out_ov !== 1'b0) $display("FAIL reset_out_data: got %h/%b want 0/0", out_q, out_ov); else n_pass++;
      n_checks++; if (ov_count !== 8'd0 || ov_sticky !== 1'b0) $display("FAIL reset_ov: got %0d/%b want 0/0", ov_count, ov_sticky); else n_pass++;
      n_checks++; if (sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", sum); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [3:0] eq  [4];
      logic       eov [4];
      eq  = '{4'h8, 4'hF, 4'h3, 4'h7};
      eov = '{1'b1, 1'b0, 1'b0, 1'b1};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push1(eq[i], eov[i]);
      n_checks++; if (count !== 3'd4) $display("FAIL fill_count: got %0d want 4", count); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else n_pass++;
      n_checks++; if (ov_count !== 8'd2) $display("FAIL fill_ov_count: got %0d want 2", ov_count); else n_pass++;
      n_checks++; if (ov_sticky !== 1'b1) $display("FAIL fill_sticky: got %b want 1", ov_sticky); else n_pass++;
      n_checks++; if (sum !== 8'h01) $display("FAIL fill_sum: got %h want 01", sum); else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_q !== eq[i] || out_ov !== eov[i])
            $display("FAIL drain_head%0d: got v=%b %h/%b want v=1 %h/%b", i, out_valid, out_q, out_ov, eq[i], eov[i]);
         else n_pass++;
         cycle();
      end
      n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL drain_empty: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count); else n_pass++;
      n_checks++; if (out_q !== 4'h0 || out_ov !== 1'b0) $display("FAIL drain_empty_data: got %h/%b want 0/0", out_q, out_ov); else n_pass++;
      out_ready = 1'b0;
   endtask

   task automatic test_full_push_pop();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push1(4'($urandom), 1'($urandom));
      n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else n_pass++;
      in_valid = 1'b1; in_q = 4'($urandom); in_ov = 1'($urandom); out_ready = 1'b1;
      cycle();
      n_checks++; if (count !== 3'd3) $display("FAIL full_refuse_count: got %0d want 3", count); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         in_q = 4'($urandom); in_ov = 1'($urandom);
         cycle();
         n_checks++; if (count !== 3'd3) $display("FAIL bb_count%0d: got %0d want 3", i, count); else n_pass++;
         n_checks++;
         if (out_q !== m_q[0].q || out_ov !== m_q[0].ov)
            $display("FAIL bb_head%0d: got %h/%b want %h/%b", i, out_q, out_ov, m_q[0].q, m_q[0].ov);
         else n_pass++;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (out_q !== m_q[0].q || out_ov !== m_q[0].ov)
            $display("FAIL wrap_drain%0d: got %h/%b want %h/%b", i, out_q, out_ov, m_q[0].q, m_q[0].ov);
         else n_pass++;
         cycle();
      end
      n_checks++; if (out_valid !== 1'b0) $display("FAIL wrap_empty: got %b want 0", out_valid); else n_pass++;
      out_ready = 1'b0;
   endtask

   task automatic test_saturation_wrap();
      clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; in_ov = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_q = 4'($urandom);
         cycle();
         if (i == 254) begin
            n_checks++; if (ov_count !== 8'd255) $display("FAIL sat_reach: got %0d want 255", ov_count); else n_pass++;
         end
      end
      n_checks++; if (ov_count !== 8'd255) $display("FAIL sat_hold: got %0d want 255", ov_count); else n_pass++;
      n_checks++; if (sum !== 8'(m_sum)) $display("FAIL sat_sum: got %h want %h", sum, 8'(m_sum)); else n_pass++;
      in_valid = 1'b0; cycle();
      clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
      in_valid = 1'b1; in_q = 4'h7; in_ov = 1'b0;
      repeat (32) cycle();
      in_valid = 1'b0;
      n_checks++; if (sum !== 8'hE0) $display("FAIL sum_wrap: got %h want e0", sum); else n_pass++;
      n_checks++; if (ov_count !== 8'd0 || ov_sticky !== 1'b0) $display("FAIL wrap_ov: got %0d/%b want 0/0", ov_count, ov_sticky); else n_pass++;
      cycle();
      out_ready = 1'b0;
   endtask

   task automatic test_clear_priority();
      out_ready = 1'b0;
      push1(4'h3, 1'b1);
      clr_stats = 1'b1; in_valid = 1'b1; in_q = 4'h5; in_ov = 1'b1;
      cycle();
      clr_stats = 1'b0; in_valid = 1'b0;
      n_checks++; if (sum !== 8'h00) $display("FAIL clr_sum: got %h want 00", sum); else n_pass++;
      n_checks++; if (ov_count !== 8'd0 || ov_sticky !== 1'b0) $display("FAIL clr_ov: got %0d/%b want 0/0", ov_count, ov_sticky); else n_pass++;
      n_checks++; if (count !== 3'd2) $display("FAIL clr_count: got %0d want 2", count); else n_pass++;
      out_ready = 1'b1;
      n_checks++; if (out_q !== 4'h3 || out_ov !== 1'b1) $display("FAIL clr_pop0: got %h/%b want 3/1", out_q, out_ov); else n_pass++;
      cycle();
      n_checks++; if (out_q !== 4'h5 || out_ov !== 1'b1) $display("FAIL clr_pop1: got %h/%b want 5/1", out_q, out_ov); else n_pass++;
      cycle();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL clr_empty: got %b want 0", out_valid); else n_pass++;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
      for (int i = 0; i < 3; i++) push1(4'hE, 1'b0);
      n_checks++; if (count !== 3'd3 || sum !== 8'hFA) $display("FAIL mid_pre: got cnt=%0d sum=%h want cnt=3 sum=fa", count, sum); else n_pass++;
      #3 rst = 1'b1;
      #1;
      m_reset();
      n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL mid_rst: got v=%b cnt=%0d want v=0 cnt=0", out_valid, count); else n_pass++;
      n_checks++; if (sum !== 8'h00 || in_ready !== 1'b1) $display("FAIL mid_rst_sum: got sum=%h rdy=%b want sum=00 rdy=1", sum, in_ready); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      push1(4'h2, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_q !== 4'h2) $display("FAIL mid_head: got v=%b %h want v=1 2", out_valid, out_q); else n_pass++;
      n_checks++; if (sum !== 8'h02 || count !== 3'd1) $display("FAIL mid_after: got sum=%h cnt=%0d want sum=02 cnt=1", sum, count); else n_pass++;
      out_ready = 1'b1; cycle(); out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0] eq;
      logic       eov;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clr_stats = ($urandom_range(0, 19) == 0);
         in_q      = 4'($urandom);
         in_ov     = 1'($urandom);
         cycle();
         eq  = (m_q.size() > 0) ? m_q[0].q  : 4'h0;
         eov = (m_q.size() > 0) ? m_q[0].ov : 1'b0;
         n_checks++; if (count !== 3'(m_q.size())) $display("FAIL rnd_count%0d: got %0d want %0d", i, count, m_q.size()); else n_pass++;
         n_checks++; if (in_ready !== (m_q.size() < DEPTH) || out_valid !== (m_q.size() > 0))
            $display("FAIL rnd_flags%0d: got rdy=%b v=%b want size %0d", i, in_ready, out_valid, m_q.size()); else n_pass++;
         n_checks++; if (out_q !== eq || out_ov !== eov) $display("FAIL rnd_head%0d: got %h/%b want %h/%b", i, out_q, out_ov, eq, eov); else n_pass++;
         n_checks++; if (ov_count !== 8'(m_ovc) || ov_sticky !== m_sticky)
            $display("FAIL rnd_ov%0d: got %0d/%b want %0d/%b", i, ov_count, ov_sticky, m_ovc, m_sticky); else n_pass++;
         n_checks++; if (sum !== 8'(m_sum)) $display("FAIL rnd_sum%0d: got %h want %h", i, sum, 8'(m_sum)); else n_pass++;
      end
      in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_push_pop();
      test_saturation_wrap();
      test_clear_priority();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/arith_result_fifo.md
# arith_result_fifo

Buffers results produced by the 4-bit signed `arithmetic_unit` stage and hands them to a downstream consumer over a valid/ready handshake. Each accepted entry carries the signed result `Q` and its `overflow` flag. The block also keeps running statistics over all accepted entries: an overflow count, a sticky overflow flag and a wrapping signed sum. It sits directly downstream of `arithmetic_unit`, with `in_q`/`in_ov` wired to `Q`/`overflow`.

## Interface
- `WIDTH`, 4: result width; must match `arithmetic_unit.Q`.
- `DEPTH`, 4: number of FIFO entries; power of two, at least 2.
- `CNT_W`, 8: width of the overflow counter.
- `ACC_W`, 8: width of the signed running sum.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream presents a result.
- `in_ready` out 1: FIFO can accept a result.
- `in_q` in WIDTH: signed result from `arithmetic_unit.Q`.
- `in_ov` in 1: overflow flag from `arithmetic_unit.overflow`.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: consumer takes the head entry.
- `out_q` out WIDTH: signed head result.
- `out_ov` out 1: head overflow flag.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `ov_count` out CNT_W: number of accepted entries with `in_ov`=1; saturates.
- `ov_sticky` out 1: set by any accepted overflow.
- `sum` out ACC_W: signed wrapping sum of accepted `in_q`.
- `clr_stats` in 1: synchronous clear of `ov_count`, `ov_sticky` and `sum`.

## Operation
- Push: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- Storage is a circular buffer with write and read pointers of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0. `count` tracks occupancy explicitly.
- `in_ready = (count != DEPTH)`. It does not depend on `out_ready`, so a full FIFO refuses a push even when a pop happens in the same cycle.
- `out_valid = (count != 0)`.
- `out_q`/`out_ov` show the entry at the read pointer, read first-word-fall-through. Both are forced to 0 while the FIFO is empty.
- Simultaneous push and pop:
  - The FIFO cannot be empty in this case, because a pop needs `out_valid`.
  - Both pointers advance and `count` is unchanged.
- Push only: `count`+1. Pop only: `count`-1.
- Statistics update only on a push, never on a pop:
  - `sum <= sum + sign_extend(in_q)`, computed modulo 2^ACC_W.
  - If `in_ov`=1: `ov_count` increments, holding at 2^CNT_W-1, and `ov_sticky` is set.
- `clr_stats` has priority over a push in the same cycle. The pushed entry is still stored, but it does not contribute to `sum`, `ov_count` or `ov_sticky`.
- `rst` asserted at any time, including mid-burst, does all of the following immediately:
  - Empties the FIFO and zeroes both pointers.
  - Drives `count`=0, `out_valid`=0, `out_q`=0, `out_ov`=0, `in_ready`=1.
  - Zeroes `ov_count`, `ov_sticky` and `sum`.
  - Stored entries are discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_q`=0, `out_ov`=0, `count`=0, `ov_count`=0, `ov_sticky`=0, `sum`=0.
- Latency: an entry pushed at edge N drives `out_valid`=1 with its data in the cycle after edge N. There is no extra bubble.
- `count`, `in_ready`, `ov_count`, `ov_sticky` and `sum` all reflect a push or pop in the cycle after the edge that performs it.
- Throughput: one push and one pop per cycle while the FIFO is neither empty nor full.
- `out_q`/`out_ov` stay stable while `out_valid`=1 and `out_ready`=0.
- The upstream block is combinational. `in_q` and `in_ov` are sampled only at an accepting edge.

## Test plan
- Reset check: assert `rst` mid-cycle with no clock edge. All outputs go to their reset values immediately, with `in_ready`=1 and `count`=0.
- Fill and drain, `out_ready`=0:
  - Push `in_q` = -8, -1, 3, 7 with `in_ov` = 1, 0, 0, 1. Result: `count`=4, `in_ready`=0, `ov_count`=2, `ov_sticky`=1, `sum`=1 (0x01).
  - Then raise `out_ready`. Pops return -8/1, -1/0, 3/0, 7/1 in order, and `out_valid` falls after the fourth pop.
- Full plus simultaneous push/pop: with `count`=4, drive `in_valid`=1 and `out_ready`=1 for one cycle. Only the pop happens, and `count`=3. The next cycle, with both active, keeps `count`=3, and the pointers wrap past DEPTH-1 with data order preserved.
- Saturation and wrap:
  - Push 300 entries with `in_ov`=1. `ov_count` holds at 255.
  - Push 32 entries of `in_q`=7 from `sum`=0. `sum` wraps to 224, i.e. -32 (0xE0).
- Clear priority: assert `clr_stats` in the same cycle as a push of `in_q`=5, `in_ov`=1. Result: `sum`=0, `ov_count`=0, `ov_sticky`=0, but the entry is stored (`count`+1, and it later pops as 5/1).
- Reset mid-operation: with `count`=3 and `sum`=-6, assert `rst` asynchronously. `out_valid` drops at once. After release, the first push of 2 appears at the head, and `sum`=2.
